// File: rtl/usb_epbuf_arbiter.sv
// usb_epbuf_arbiter: shares one single-port endpoint buffer RAM between the USB SIE
// (fixed priority) and the CPU bridge. A starvation guard forces a CPU slot after
// STARVE_MAX consecutive contended SIE grants. A SIE packet lock excludes the CPU
// for a whole packet.
// Optional build macro USBDEV_ARB_CONFLICT_CNT_EN adds a saturating conflict counter
// (ports conflict_cnt / conflict_clr).
module usb_epbuf_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
  output logic [7:0]        conflict_cnt,
  input  logic              conflict_clr,
`endif
  input  logic              sie_req,
  input  logic              sie_we,
  input  logic [ADDR_W-1:0] sie_addr,
  input  logic [DATA_W-1:0] sie_wdata,
  input  logic              sie_lock,
  output logic              sie_gnt,
  output logic              sie_rvalid,
  output logic [DATA_W-1:0] sie_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StOpen, StLocked} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              sie_rvalid_q, sie_rvalid_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] sie_hold_q, sie_hold_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic              contended;

  assign contended = sie_req & cpu_req;

  // State, starvation counter and read-return registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StOpen;
      starve_q     <= 4'd0;
      sie_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      sie_hold_q   <= '0;
      cpu_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      sie_rvalid_q <= sie_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      sie_hold_q   <= sie_hold_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  // Next-state: packet lock opens/closes on the SIE lock request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOpen:   if (sie_lock)  state_d = StLocked;
      StLocked: if (!sie_lock) state_d = StOpen;
      default:  state_d = StOpen;
    endcase
  end

  // Grants, RAM mux and starvation bookkeeping; grants are forced low while in reset
  always_comb begin
    sie_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    if (!rst) begin
      if (state_q == StLocked) begin
        sie_gnt = sie_req;
      end else if (contended) begin
        if (starve_q >= StarveMax) cpu_gnt = 1'b1;
        else                       sie_gnt = 1'b1;
      end else begin
        sie_gnt = sie_req;
        cpu_gnt = cpu_req;
      end
    end

    // Only a contended cycle lost by the CPU in OPEN advances the guard
    if (state_q == StOpen && contended && !cpu_gnt) starve_d = starve_q + 4'd1;
    else                                            starve_d = 4'd0;

    mem_en    = sie_gnt | cpu_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sie_gnt) begin
      mem_we    = sie_we;
      mem_addr  = sie_addr;
      mem_wdata = sie_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end

    sie_rvalid_d = sie_gnt & ~sie_we;
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    sie_hold_d   = sie_rvalid_q ? mem_rdata : sie_hold_q;
    cpu_hold_d   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
  end

  // Read return: RAM data passes straight through in the valid cycle, then is held
  always_comb begin
    sie_rvalid = sie_rvalid_q;
    cpu_rvalid = cpu_rvalid_q;
    sie_rdata  = sie_rvalid_q ? mem_rdata : sie_hold_q;
    cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    locked     = (state_q == StLocked);
  end

`ifdef USBDEV_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_q, conflict_d;

  // Saturating count of cycles where the CPU was kept waiting; clear wins
  always_comb begin
    conflict_d = conflict_q;
    if (conflict_clr)                                 conflict_d = 8'd0;
    else if (contended && !cpu_gnt && conflict_q != 8'hff) conflict_d = conflict_q + 8'd1;
  end

  // Conflict counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_q <= 8'd0;
    else     conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_usb_epbuf_arbiter.sv
// Self-checking bench for usb_epbuf_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_usb_epbuf_arbiter;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sie_req, sie_we, sie_lock, cpu_req, cpu_we;
  logic [5:0] sie_addr, cpu_addr, mem_addr;
  logic [7:0] sie_wdata, cpu_wdata, mem_wdata, mem_rdata, sie_rdata, cpu_rdata;
  logic       sie_gnt, sie_rvalid, cpu_gnt, cpu_rvalid, mem_en, mem_we, locked;
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
  logic       conflict_clr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usb_epbuf_arbiter #(.ADDR_W(6), .DATA_W(8), .STARVE_MAX(SW)) dut (
    .clk(clk), .rst(rst),
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt), .conflict_clr(conflict_clr),
`endif
    .sie_req(sie_req), .sie_we(sie_we), .sie_addr(sie_addr), .sie_wdata(sie_wdata),
    .sie_lock(sie_lock), .sie_gnt(sie_gnt), .sie_rvalid(sie_rvalid), .sie_rdata(sie_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  // Buffer RAM: synchronous single-port, read data one cycle after enable
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: lock flag, count of CPU losses in a row, expected read returns
  logic [7:0] ref_mem [64];
  int         m_wait;
  logic       m_lock, m_srv, m_crv;
  logic [7:0] m_srd, m_crd;
  int         m_conf;
  logic [1:0] g;  // {cpu, sie} predicted grant
  logic [36:0] exp_vec, obs_vec;

  always_comb begin
    g = 2'b00;
    if (!rst) begin
      if (m_lock)                 g = {1'b0, sie_req};
      else if (sie_req && cpu_req) g = (m_wait >= SW) ? 2'b10 : 2'b01;
      else                        g = {cpu_req, sie_req};
    end
    exp_vec = {g[0], g[1], m_srv, m_crv, m_lock, m_srd, m_crd, 16'd0};
    if (g[0])      exp_vec[15:0] = {1'b1, sie_we, sie_addr, sie_wdata};
    else if (g[1]) exp_vec[15:0] = {1'b1, cpu_we, cpu_addr, cpu_wdata};
  end

  assign obs_vec = {sie_gnt, cpu_gnt, sie_rvalid, cpu_rvalid, locked, sie_rdata, cpu_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 0; m_lock <= 1'b0; m_srv <= 1'b0; m_crv <= 1'b0;
      m_srd <= 8'd0; m_crd <= 8'd0; m_conf <= 0;
    end else begin
      m_srv <= g[0] && !sie_we;
      m_crv <= g[1] && !cpu_we;
      if (g[0] && !sie_we) m_srd <= ref_mem[sie_addr];
      if (g[1] && !cpu_we) m_crd <= ref_mem[cpu_addr];
      if (g[0] && sie_we) ref_mem[sie_addr] <= sie_wdata;
      if (g[1] && cpu_we) ref_mem[cpu_addr] <= cpu_wdata;
      m_wait <= (!m_lock && sie_req && cpu_req && g[0]) ? m_wait + 1 : 0;
      m_lock <= sie_lock;
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
      if (conflict_clr) m_conf <= 0;
      else if (sie_req && cpu_req && !g[1] && m_conf < 255) m_conf <= m_conf + 1;
`endif
    end
  end

  task automatic idle_inputs();
    sie_req = 1'b0; sie_we = 1'b0; sie_addr = '0; sie_wdata = '0; sie_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
    conflict_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    tests++;
    if (obs_vec !== 37'd0) begin
      $display("FAIL reset_state: got %h want 0", obs_vec); fails++;
    end
    rst = 1'b0;
    sie_req = 1'b1; sie_we = 1'b0; sie_addr = 6'h05;
    @(negedge clk);
    tests++;
    if (sie_gnt !== 1'b1) begin
      $display("FAIL reset_pre_read_gnt: got %b want 1", sie_gnt); fails++;
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (obs_vec !== 37'd0) begin
      $display("FAIL reset_mid_read: got %h want 0", obs_vec); fails++;
    end
    @(posedge clk); #1;
    rst = 1'b0; sie_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (sie_rvalid !== 1'b0 || obs_vec !== exp_vec) begin
        $display("FAIL reset_no_rvalid[%0d]: got %h want %h", i, obs_vec, exp_vec); fails++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_cpu();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h10; cpu_wdata = 8'hA5;
    @(negedge clk);
    tests++;
    if (cpu_gnt !== 1'b1 || obs_vec !== exp_vec) begin
      $display("FAIL cpu_write: got %h want %h", obs_vec, exp_vec); fails++;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
      $display("FAIL cpu_read_gnt: got gnt=%b rvalid=%b want 1/0", cpu_gnt, cpu_rvalid); fails++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5) begin
      $display("FAIL cpu_read_data: got rvalid=%b data=%h want 1/a5", cpu_rvalid, cpu_rdata);
      fails++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin
      $display("FAIL cpu_read_hold: got rvalid=%b data=%h want 0/a5", cpu_rvalid, cpu_rdata);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [9:0] sh, ch;
    logic [6:0] ch2;
    sie_req = 1'b1; sie_we = 1'b1; sie_addr = 6'h20;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h21;
    for (int i = 0; i < 10; i++) begin
      sie_wdata = 8'($urandom); cpu_wdata = 8'($urandom);
      @(negedge clk);
      sh[i] = sie_gnt; ch[i] = cpu_gnt;
      tests++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL contention_cycle[%0d]: got %h want %h", i, obs_vec, exp_vec); fails++;
      end
      @(posedge clk); #1;
    end
    tests++;
    // S,S,S,S,C,S,S,S,S,C with bit i = cycle i
    if (ch !== 10'h210 || sh !== 10'h1EF) begin
      $display("FAIL contention_pattern: got cpu=%b sie=%b want cpu=%b sie=%b",
               ch, sh, 10'h210, 10'h1EF);
      fails++;
    end
    // CPU steps away for two cycles, then re-requests: guard restarts from zero
    cpu_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) cpu_req = 1'b1;
      @(negedge clk);
      ch2[i] = cpu_gnt;
      @(posedge clk); #1;
    end
    tests++;
    if (ch2 !== 7'b1000000) begin
      $display("FAIL contention_restart: got %b want %b", ch2, 7'b1000000); fails++;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    int  waited;
    logic got;
    sie_lock = 1'b1;
    sie_req = 1'b1; sie_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h3;
    for (int i = 0; i < 12; i++) begin
      sie_addr = 6'(i);
      @(negedge clk);
      tests++;
      if (sie_gnt !== 1'b1 || cpu_gnt !== 1'b0 || locked !== (i >= 1) || obs_vec !== exp_vec) begin
        $display("FAIL lock_cycle[%0d]: got %h (locked=%b) want %h", i, obs_vec, locked, exp_vec);
        fails++;
      end
      @(posedge clk); #1;
    end
    sie_lock = 1'b0;
    got = 1'b0; waited = 0;
    // Release cycle plus STARVE_MAX+1 cycles of OPEN arbitration
    while (!got && waited < SW + 2) begin
      @(negedge clk);
      got = cpu_gnt;
      tests++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL unlock_cycle[%0d]: got %h want %h", waited, obs_vec, exp_vec); fails++;
      end
      waited++;
      @(posedge clk); #1;
    end
    tests++;
    if (!got) begin
      $display("FAIL unlock_cpu_gnt: got none after %0d cycles want one", waited); fails++;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_interleaved();
    sie_req = 1'b1; sie_we = 1'b1; sie_addr = 6'h00; sie_wdata = 8'h11;
    @(posedge clk); #1;
    sie_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h01; cpu_wdata = 8'h22;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    sie_req = 1'b1; sie_we = 1'b0; sie_addr = 6'h00;
    @(posedge clk); #1;
    sie_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h01;
    @(negedge clk);
    tests++;
    if (sie_rvalid !== 1'b1 || sie_rdata !== 8'h11 || cpu_gnt !== 1'b1) begin
      $display("FAIL interleave_sie: got rvalid=%b data=%h gnt=%b want 1/11/1",
               sie_rvalid, sie_rdata, cpu_gnt);
      fails++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h22 || sie_rvalid !== 1'b0 ||
        sie_rdata !== 8'h11) begin
      $display("FAIL interleave_cpu: got c=%b/%h s=%b/%h want 1/22 0/11",
               cpu_rvalid, cpu_rdata, sie_rvalid, sie_rdata);
      fails++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h22 || sie_rdata !== 8'h11) begin
      $display("FAIL interleave_hold: got c=%b/%h s=%h want 0/22 11",
               cpu_rvalid, cpu_rdata, sie_rdata);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic sg, cg;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sg = g[0]; cg = g[1];
      tests++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec, exp_vec); fails++;
      end
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
      tests++;
      if (conflict_cnt !== 8'(m_conf)) begin
        $display("FAIL random_conflict[%0d]: got %0d want %0d", i, conflict_cnt, m_conf); fails++;
      end
`endif
      @(posedge clk); #1;
      // A request holds its fields until granted
      if (!sie_req || sg) begin
        sie_req = ($urandom_range(0, 3) != 0); sie_we = 1'($urandom);
        sie_addr = 6'($urandom); sie_wdata = 8'($urandom);
      end
      if (!cpu_req || cg) begin
        cpu_req = ($urandom_range(0, 2) != 0); cpu_we = 1'($urandom);
        cpu_addr = 6'($urandom); cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) sie_lock = ~sie_lock;
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
      conflict_clr = ($urandom_range(0, 30) == 0);
`endif
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

`ifdef USBDEV_ARB_CONFLICT_CNT_EN
  task automatic test_conflict();
    conflict_clr = 1'b1;
    @(posedge clk); #1;
    conflict_clr = 1'b0;
    // Lock keeps the CPU out, so every one of the 300 cycles is a conflict
    sie_lock = 1'b1; sie_req = 1'b1; sie_we = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    repeat (300) begin @(posedge clk); #1; end
    @(negedge clk);
    tests++;
    if (conflict_cnt !== 8'd255) begin
      $display("FAIL conflict_saturate: got %0d want 255", conflict_cnt); fails++;
    end
    @(posedge clk); #1;
    conflict_clr = 1'b1;
    @(posedge clk); #1;
    conflict_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (conflict_cnt !== 8'd0) begin
      $display("FAIL conflict_clear: got %0d want 0", conflict_cnt); fails++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (conflict_cnt !== 8'd1) begin
      $display("FAIL conflict_after_clear: got %0d want 1", conflict_cnt); fails++;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_cpu();
    test_contention();
    test_lock();
    test_interleaved();
    test_random();
`ifdef USBDEV_ARB_CONFLICT_CNT_EN
    test_conflict();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
